// File: rtl/halo_exchange_controller.sv
// halo_exchange_controller
// Runs the halo-exchange phase for one channel group. It sends local halo
// partial sums to the eight neighbour tiles and buffers incoming neighbour
// writes in eight 2-entry FIFOs. The FIFOs drain round-robin into the
// accumulator-buffer accumulate port. cycle_done pulses once everything has
// been sent, every neighbour has reported done, and all FIFOs are empty.
module halo_exchange_controller #(
    parameter int  TILE_SIZE      = 128,
    parameter int  NEIGHBOR_COUNT = 8,
    localparam int CW             = $clog2(TILE_SIZE)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      channel_group_done,
    input  logic                      halo_empty,
    input  logic                      out_valid,
    output logic                      out_ready,
    input  logic [2:0]                out_neighbor,
    input  logic [CW-1:0]             out_row,
    input  logic [CW-1:0]             out_column,
    input  logic [7:0]                out_value,
    input  logic                      out_last,
    input  logic [NEIGHBOR_COUNT-1:0] neighbor_cts,
    output logic [7:0]                neighbor_output_value        [NEIGHBOR_COUNT],
    output logic [CW-1:0]             neighbor_output_row          [NEIGHBOR_COUNT],
    output logic [CW-1:0]             neighbor_output_column       [NEIGHBOR_COUNT],
    output logic [NEIGHBOR_COUNT-1:0] neighbor_output_write_enable,
    input  logic [7:0]                neighbor_input_value         [NEIGHBOR_COUNT],
    input  logic [CW-1:0]             neighbor_input_row           [NEIGHBOR_COUNT],
    input  logic [CW-1:0]             neighbor_input_column        [NEIGHBOR_COUNT],
    input  logic [NEIGHBOR_COUNT-1:0] neighbor_input_write_enable,
    input  logic [NEIGHBOR_COUNT-1:0] neighbor_exchange_done,
    output logic                      clear_to_send,
    output logic                      exchange_done,
    output logic                      buf_valid,
    input  logic                      buf_ready,
    output logic [CW-1:0]             buf_row,
    output logic [CW-1:0]             buf_column,
    output logic [7:0]                buf_value,
    output logic                      cycle_done,
    output logic                      exchange_error
);

    localparam int IDW = 3;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, FINISH} state_t;

    state_t state_reg;

    logic           handshake;
    logic           pop_en;
    logic           grant_valid;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] rr_reg;
    logic           fifos_ok;
    logic           all_drained;

    logic [NEIGHBOR_COUNT-1:0]         push;
    logic [NEIGHBOR_COUNT-1:0]         pop;
    logic [NEIGHBOR_COUNT-1:0]         drop;
    logic [NEIGHBOR_COUNT-1:0]         nonempty;
    logic [NEIGHBOR_COUNT-1:0]         count_le1;
    logic [NEIGHBOR_COUNT-1:0][CW-1:0] head_row;
    logic [NEIGHBOR_COUNT-1:0][CW-1:0] head_column;
    logic [NEIGHBOR_COUNT-1:0][7:0]    head_value;

    // Outgoing stream is only accepted while sending, and only when the
    // addressed neighbour can take a write this cycle.
    assign out_ready = (state_reg == SEND) && neighbor_cts[out_neighbor];
    assign handshake = out_valid && out_ready;

    // clear_to_send is registered, so it must look at the next-state counts.
    // That way a neighbour that saw it high can still write without overflow.
    assign fifos_ok    = &count_le1;
    assign all_drained = (&neighbor_exchange_done) && !(|nonempty);

    // Phase sequencer with registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            exchange_done <= 1'b0;
            clear_to_send <= 1'b0;
            cycle_done    <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    clear_to_send <= channel_group_done && fifos_ok;
                    if (channel_group_done) begin
                        if (halo_empty) begin
                            state_reg     <= WAIT;
                            exchange_done <= 1'b1;
                        end else begin
                            state_reg <= SEND;
                        end
                    end
                end
                SEND: begin
                    clear_to_send <= fifos_ok;
                    if (handshake && out_last) begin
                        state_reg     <= WAIT;
                        exchange_done <= 1'b1;
                    end
                end
                WAIT: begin
                    clear_to_send <= fifos_ok;
                    if (all_drained) begin
                        state_reg  <= FINISH;
                        cycle_done <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    exchange_done <= 1'b0;
                    clear_to_send <= 1'b0;
                end
            endcase
        end
    end

    // Neighbour write ports: only the addressed port is updated, and its enable pulses for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
                neighbor_output_value[i]  <= '0;
                neighbor_output_row[i]    <= '0;
                neighbor_output_column[i] <= '0;
            end
            neighbor_output_write_enable <= '0;
        end else begin
            neighbor_output_write_enable <= '0;
            if (handshake) begin
                neighbor_output_write_enable[out_neighbor] <= 1'b1;
                neighbor_output_value[out_neighbor]        <= out_value;
                neighbor_output_row[out_neighbor]          <= out_row;
                neighbor_output_column[out_neighbor]       <= out_column;
            end
        end
    end

    // Per-neighbour 2-entry FIFOs. A write that arrives while the FIFO is
    // full, or while the tile is idle, is dropped and flagged as an error.
    for (genvar gi = 0; gi < NEIGHBOR_COUNT; gi++) begin : g_fifo
        logic [CW-1:0] row_mem    [2];
        logic [CW-1:0] column_mem [2];
        logic [7:0]    value_mem  [2];
        logic          wr_ptr_reg;
        logic          rd_ptr_reg;
        logic [1:0]    count_reg;
        logic [1:0]    count_next;

        assign push[gi]        = neighbor_input_write_enable[gi] && (state_reg != IDLE)
                                 && (count_reg != 2'd2);
        assign drop[gi]        = neighbor_input_write_enable[gi] && !push[gi];
        assign pop[gi]         = pop_en && (grant == IDW'(gi));
        assign nonempty[gi]    = (count_reg != 2'd0);
        assign count_le1[gi]   = ~count_next[1];
        assign head_row[gi]    = row_mem[rd_ptr_reg];
        assign head_column[gi] = column_mem[rd_ptr_reg];
        assign head_value[gi]  = value_mem[rd_ptr_reg];

        // Occupancy after this cycle's push/pop; a simultaneous push and pop leaves it unchanged.
        always_comb begin
            count_next = count_reg;
            if (push[gi] && !pop[gi]) begin
                count_next = count_reg + 2'd1;
            end else if (pop[gi] && !push[gi]) begin
                count_next = count_reg - 2'd1;
            end
        end

        // Entry storage; contents are don't-care until the count covers them.
        always_ff @(posedge clk) begin
            if (push[gi]) begin
                row_mem[wr_ptr_reg]    <= neighbor_input_row[gi];
                column_mem[wr_ptr_reg] <= neighbor_input_column[gi];
                value_mem[wr_ptr_reg]  <= neighbor_input_value[gi];
            end
        end

        // Pointer and count bookkeeping; reset flushes the FIFO.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr_reg <= 1'b0;
                rd_ptr_reg <= 1'b0;
                count_reg  <= 2'd0;
            end else begin
                if (push[gi]) begin
                    wr_ptr_reg <= ~wr_ptr_reg;
                end
                if (pop[gi]) begin
                    rd_ptr_reg <= ~rd_ptr_reg;
                end
                count_reg <= count_next;
            end
        end
    end

    // Round-robin grant: the first non-empty FIFO at or after rr, wrapping at eight.
    always_comb begin
        logic [IDW-1:0] idx;
        idx         = '0;
        grant_valid = 1'b0;
        grant       = '0;
        for (int k = 0; k < NEIGHBOR_COUNT; k++) begin
            idx = rr_reg + IDW'(k);
            if (!grant_valid && nonempty[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

    assign pop_en     = grant_valid && buf_ready;
    assign buf_valid  = grant_valid;
    assign buf_row    = grant_valid ? head_row[grant]    : '0;
    assign buf_column = grant_valid ? head_column[grant] : '0;
    assign buf_value  = grant_valid ? head_value[grant]  : '0;

    // Arbiter pointer advances past the served FIFO; the error flag is sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_reg         <= '0;
            exchange_error <= 1'b0;
        end else begin
            if (pop_en) begin
                rr_reg <= grant + IDW'(1);
            end
            if (|drop) begin
                exchange_error <= 1'b1;
            end
        end
    end

endmodule
